line_fill_ctrl: RTL and testbench

//  Write-side front end of the cache data array. Produces the 32-bit byte-write strobe and the
//  256-bit line image consumed by dataBlock. Two sources:
//  - an 8-beat critical-word-first refill from memory;
//  - single-word CPU stores with byte masks.

---
 rtl/line_fill_ctrl_pkg.sv | 24 ++
 rtl/line_lane_pack.sv | 31 +++
 rtl/line_fill_ctrl.sv | 138 +++++++++++++
 tb/tb_line_fill_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/line_fill_ctrl_pkg.sv
// Shared definitions for the cache line write front end: line geometry,
// refill FSM states and the byte-strobe placement helper.
package line_fill_ctrl_pkg;

   localparam int unsigned WORDS  = 8;
   localparam int unsigned WORD_W = 32;
   localparam int unsigned LINE_W = WORDS * WORD_W;
   localparam int unsigned BE_W   = LINE_W / 8;
   localparam int unsigned WBE_W  = WORD_W / 8;
   localparam int unsigned IDX_W  = $clog2(WORDS);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      FILL = 2'd2
   } fill_state_t;

   // Place a per-word byte mask at word slot idx of the line strobe vector.
   function automatic logic [BE_W-1:0] lane_strobe(input logic [IDX_W-1:0] idx,
                                                   input logic [WBE_W-1:0] mask);
      return BE_W'(mask) << (32'(idx) * WBE_W);
   endfunction

endpackage

// File: rtl/line_lane_pack.sv
// Combinational placement of one word into a cache line image.
// Ports:
//   idx   - word slot within the line
//   mask  - byte enables within the word
//   data  - word data
//   write - line-wide byte strobes (mask shifted to slot idx)
//   block - line image, data in slot idx, every unwritten byte 0
module line_lane_pack
   import line_fill_ctrl_pkg::*;
(
   input  logic [IDX_W-1:0]  idx,
   input  logic [WBE_W-1:0]  mask,
   input  logic [WORD_W-1:0] data,
   output logic [BE_W-1:0]   write,
   output logic [LINE_W-1:0] block
);

   logic [WORD_W-1:0] masked;

   // Zero the bytes that are not enabled so the line image is clean.
   always_comb begin
      masked = '0;
      for (int b = 0; b < int'(WBE_W); b++) begin
         if (mask[b]) masked[8*b +: 8] = data[8*b +: 8];
      end
   end

   assign write = lane_strobe(idx, mask);
   assign block = LINE_W'(masked) << (32'(idx) * WORD_W);

endmodule

// File: rtl/line_fill_ctrl.sv
// Write-side front end of the cache data array. Merges an 8-beat
// critical-word-first refill and single-word CPU stores into registered
// byte strobes (write) and a line image (block) for dataBlock.
// Ports:
//   clk, reset                    - clock, synchronous active-high reset
//   fill_valid/ready, fill_addr   - refill request handshake
//   mem_req_valid/ready/addr      - memory burst request
//   mem_rvalid/rready/rdata       - memory read beats
//   store_valid/ready, store_word,
//   store_mask, store_data        - CPU store handshake
//   write, block                  - one-cycle write pulse to dataBlock
//   fill_busy, fill_done          - refill status
module line_fill_ctrl
   import line_fill_ctrl_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              fill_valid,
   output logic              fill_ready,
   input  logic [31:0]       fill_addr,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic [31:0]       mem_req_addr,
   input  logic              mem_rvalid,
   output logic              mem_rready,
   input  logic [WORD_W-1:0] mem_rdata,
   input  logic              store_valid,
   output logic              store_ready,
   input  logic [IDX_W-1:0]  store_word,
   input  logic [WBE_W-1:0]  store_mask,
   input  logic [WORD_W-1:0] store_data,
   output logic [BE_W-1:0]   write,
   output logic [LINE_W-1:0] block,
   output logic              fill_busy,
   output logic              fill_done
);

   localparam logic [IDX_W-1:0] LAST_CNT = IDX_W'(WORDS - 1);

   fill_state_t       state;
   logic [IDX_W-1:0]  beat_idx;
   logic [IDX_W-1:0]  cnt;

   logic              beat_accept;
   logic              store_accept;
   logic              fill_accept;
   logic [IDX_W-1:0]  pack_idx;
   logic [WBE_W-1:0]  pack_mask;
   logic [WORD_W-1:0] pack_data;
   logic [BE_W-1:0]   pack_write;
   logic [LINE_W-1:0] pack_block;

   // Stores win over a simultaneous fill request and stall outside IDLE.
   assign store_ready  = (state == IDLE);
   assign fill_ready   = (state == IDLE) && !store_valid;
   assign store_accept = store_valid && store_ready;
   assign fill_accept  = fill_valid && fill_ready;
   assign beat_accept  = (state == FILL) && mem_rvalid;

   // Select the source for this cycle's write; mask 0 yields write=0, block=0.
   always_comb begin
      pack_idx  = '0;
      pack_mask = '0;
      pack_data = '0;
      if (beat_accept) begin
         pack_idx  = beat_idx;
         pack_mask = '1;
         pack_data = mem_rdata;
      end else if (store_accept) begin
         pack_idx  = store_word;
         pack_mask = store_mask;
         pack_data = store_data;
      end
   end

   line_lane_pack u_pack (
      .idx   (pack_idx),
      .mask  (pack_mask),
      .data  (pack_data),
      .write (pack_write),
      .block (pack_block)
   );

   // Refill FSM with registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         beat_idx      <= '0;
         cnt           <= '0;
         mem_req_valid <= 1'b0;
         mem_req_addr  <= '0;
         mem_rready    <= 1'b0;
         fill_busy     <= 1'b0;
         fill_done     <= 1'b0;
         write         <= '0;
         block         <= '0;
      end else begin
         fill_done <= 1'b0;
         write     <= pack_write;
         block     <= pack_block;
         case (state)
            IDLE: begin
               if (fill_accept) begin
                  state         <= REQ;
                  beat_idx      <= fill_addr[4:2];
                  cnt           <= '0;
                  mem_req_addr  <= fill_addr & ~32'h3;
                  mem_req_valid <= 1'b1;
                  fill_busy     <= 1'b1;
               end else if (fill_done) begin
                  // busy stays up through the fill_done cycle, then drops
                  fill_busy <= 1'b0;
               end
            end
            REQ: begin
               if (mem_req_ready) begin
                  state         <= FILL;
                  mem_req_valid <= 1'b0;
                  mem_rready    <= 1'b1;
               end
            end
            FILL: begin
               if (mem_rvalid) begin
                  beat_idx <= beat_idx + 1'b1;
                  cnt      <= cnt + 1'b1;
                  if (cnt == LAST_CNT) begin
                     state      <= IDLE;
                     mem_rready <= 1'b0;
                     fill_done  <= 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_line_fill_ctrl.sv
// Self-checking bench for line_fill_ctrl: directed and randomized refills,
// stores, priority and mid-fill reset against a line-placement model.
module tb_line_fill_ctrl;

   logic         clk = 1'b0;
   logic         reset;
   logic         fill_valid;
   logic         fill_ready;
   logic [31:0]  fill_addr;
   logic         mem_req_valid;
   logic         mem_req_ready;
   logic [31:0]  mem_req_addr;
   logic         mem_rvalid;
   logic         mem_rready;
   logic [31:0]  mem_rdata;
   logic         store_valid;
   logic         store_ready;
   logic [2:0]   store_word;
   logic [3:0]   store_mask;
   logic [31:0]  store_data;
   logic [31:0]  write;
   logic [255:0] block;
   logic         fill_busy;
   logic         fill_done;

   int checks = 0;
   int errors = 0;

   line_fill_ctrl dut (
      .clk           (clk),
      .reset         (reset),
      .fill_valid    (fill_valid),
      .fill_ready    (fill_ready),
      .fill_addr     (fill_addr),
      .mem_req_valid (mem_req_valid),
      .mem_req_ready (mem_req_ready),
      .mem_req_addr  (mem_req_addr),
      .mem_rvalid    (mem_rvalid),
      .mem_rready    (mem_rready),
      .mem_rdata     (mem_rdata),
      .store_valid   (store_valid),
      .store_ready   (store_ready),
      .store_word    (store_word),
      .store_mask    (store_mask),
      .store_data    (store_data),
      .write         (write),
      .block         (block),
      .fill_busy     (fill_busy),
      .fill_done     (fill_done)
   );

   always #5 clk = ~clk;

   // Reference model: byte strobes of a word slot.
   function automatic logic [31:0] exp_strobe(input int idx, input logic [3:0] mask);
      logic [31:0] s;
      s = 32'(mask);
      return s << (4 * idx);
   endfunction

   // Reference model: a line holding only data in slot idx.
   function automatic logic [255:0] exp_block(input int idx, input logic [31:0] data);
      logic [255:0] l;
      l = '0;
      l[32*idx +: 32] = data;
      return l;
   endfunction

   function automatic logic [31:0] byte_bits(input logic [3:0] mask);
      logic [31:0] m;
      for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{mask[b]}};
      return m;
   endfunction

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++; if (write !== 32'h0) begin errors++; $display("FAIL reset write got %h exp 0", write); end
      checks++; if (block !== 256'h0) begin errors++; $display("FAIL reset block got %h exp 0", block); end
      checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL reset mem_req_valid got %b exp 0", mem_req_valid); end
      checks++; if (mem_rready !== 1'b0) begin errors++; $display("FAIL reset mem_rready got %b exp 0", mem_rready); end
      checks++; if (fill_busy !== 1'b0) begin errors++; $display("FAIL reset fill_busy got %b exp 0", fill_busy); end
      checks++; if (fill_done !== 1'b0) begin errors++; $display("FAIL reset fill_done got %b exp 0", fill_done); end
      checks++; if (fill_ready !== 1'b1) begin errors++; $display("FAIL reset fill_ready got %b exp 1", fill_ready); end
      checks++; if (store_ready !== 1'b1) begin errors++; $display("FAIL reset store_ready got %b exp 1", store_ready); end
      reset = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checks++; if (write !== 32'h0) begin errors++; $display("FAIL post_reset write got %h exp 0", write); end
   endtask

   // One refill. mode: 0 back-to-back beats, 1 alternating bubbles, 2 random.
   // stop_after >= 0 applies reset after that many beats. with_store raises a
   // store during the beats that must wait until the refill finishes.
   task automatic run_fill(input string name, input logic [31:0] addr, input int mode,
                           input int stop_after, input bit with_store);
      logic [31:0] d [8];
      logic [2:0]  sw;
      logic [3:0]  sm;
      logic [31:0] sd;
      logic [31:0] care;
      int          crit;
      int          k;
      int          guard;
      int          r;
      bit          rv;
      foreach (d[i]) d[i] = $urandom;
      crit = int'(addr[4:2]);
      sw = 3'($urandom); sm = 4'($urandom_range(1, 15)); sd = $urandom;

      fill_valid = 1'b1;
      fill_addr  = addr;
      guard = 0;
      #1;
      while (!fill_ready && guard < 50) begin
         @(posedge clk); @(negedge clk); #1;
         guard++;
      end
      if (guard >= 50) begin
         errors++; checks++;
         $display("FAIL %s fill_ready timeout got %b exp 1", name, fill_ready);
         fill_valid = 1'b0;
         return;
      end
      @(posedge clk); @(negedge clk);
      fill_valid = 1'b0;
      fill_addr  = $urandom;
      checks++; if (fill_busy !== 1'b1) begin errors++; $display("FAIL %s busy_after_accept got %b exp 1", name, fill_busy); end
      checks++; if (mem_req_valid !== 1'b1) begin errors++; $display("FAIL %s req_valid got %b exp 1", name, mem_req_valid); end
      checks++; if (mem_req_addr !== {addr[31:2], 2'b00}) begin errors++; $display("FAIL %s req_addr got %h exp %h", name, mem_req_addr, {addr[31:2], 2'b00}); end

      r = $urandom_range(0, 3);
      repeat (r) begin
         @(posedge clk); @(negedge clk);
         checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== {addr[31:2], 2'b00}) begin
            errors++; $display("FAIL %s req_hold got %b/%h exp 1/%h", name, mem_req_valid, mem_req_addr, {addr[31:2], 2'b00});
         end
      end
      mem_req_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      mem_req_ready = 1'b0;
      checks++; if (mem_req_valid !== 1'b0 || mem_rready !== 1'b1) begin
         errors++; $display("FAIL %s enter_fill req_valid/rready got %b/%b exp 0/1", name, mem_req_valid, mem_rready);
      end

      if (with_store) begin
         store_valid = 1'b1; store_word = sw; store_mask = sm; store_data = sd;
      end
      k = 0;
      guard = 0;
      while (k < 8 && guard < 64) begin
         case (mode)
            0:       rv = 1'b1;
            1:       rv = (guard % 2 == 0);
            default: rv = 1'($urandom_range(0, 1));
         endcase
         mem_rvalid = rv;
         mem_rdata  = rv ? d[k] : $urandom;
         if (with_store) begin
            #1;
            checks++; if (store_ready !== 1'b0) begin errors++; $display("FAIL %s store_stall got %b exp 0", name, store_ready); end
         end
         @(posedge clk); @(negedge clk);
         guard++;
         if (rv) begin
            checks++; if (write !== exp_strobe((crit + k) % 8, 4'hF)) begin
               errors++; $display("FAIL %s beat%0d write got %h exp %h", name, k, write, exp_strobe((crit + k) % 8, 4'hF));
            end
            checks++; if (block !== exp_block((crit + k) % 8, d[k])) begin
               errors++; $display("FAIL %s beat%0d block got %h exp %h", name, k, block, exp_block((crit + k) % 8, d[k]));
            end
            checks++; if (fill_done !== (k == 7) || fill_busy !== 1'b1) begin
               errors++; $display("FAIL %s beat%0d done/busy got %b/%b exp %b/1", name, k, fill_done, fill_busy, (k == 7));
            end
            k++;
         end else begin
            checks++; if (write !== 32'h0 || fill_done !== 1'b0) begin
               errors++; $display("FAIL %s bubble write/done got %h/%b exp 0/0", name, write, fill_done);
            end
         end
         if (k == stop_after) begin
            mem_rvalid = 1'b1;
            mem_rdata  = $urandom;
            reset = 1'b1;
            @(posedge clk); @(negedge clk);
            reset = 1'b0;
            mem_rvalid = 1'b0;
            checks++; if (write !== 32'h0 || block !== 256'h0) begin errors++; $display("FAIL %s midreset write/block got %h/%h exp 0/0", name, write, block); end
            checks++; if (mem_req_valid !== 1'b0 || mem_rready !== 1'b0) begin errors++; $display("FAIL %s midreset req/rready got %b/%b exp 0/0", name, mem_req_valid, mem_rready); end
            checks++; if (fill_busy !== 1'b0 || fill_done !== 1'b0) begin errors++; $display("FAIL %s midreset busy/done got %b/%b exp 0/0", name, fill_busy, fill_done); end
            checks++; if (fill_ready !== 1'b1 || store_ready !== 1'b1) begin errors++; $display("FAIL %s midreset ready got %b/%b exp 1/1", name, fill_ready, store_ready); end
            mem_rvalid = 1'b1;
            @(posedge clk); @(negedge clk);
            mem_rvalid = 1'b0;
            checks++; if (write !== 32'h0 || fill_done !== 1'b0) begin errors++; $display("FAIL %s after_midreset write/done got %h/%b exp 0/0", name, write, fill_done); end
            return;
         end
      end
      mem_rvalid = 1'b0;
      if (k < 8) begin
         errors++; checks++;
         $display("FAIL %s beat_timeout got %0d beats exp 8", name, k);
      end

      @(posedge clk); @(negedge clk);
      if (with_store) begin
         store_valid = 1'b0;
         care = ~byte_bits(~sm);
         checks++; if (write !== exp_strobe(int'(sw), sm)) begin
            errors++; $display("FAIL %s held_store write got %h exp %h", name, write, exp_strobe(int'(sw), sm));
         end
         checks++; if ((block & ~exp_block(int'(sw), ~care)) !== exp_block(int'(sw), sd & care)) begin
            errors++; $display("FAIL %s held_store block got %h exp %h", name, block, exp_block(int'(sw), sd & care));
         end
      end else begin
         checks++; if (write !== 32'h0) begin errors++; $display("FAIL %s post_fill write got %h exp 0", name, write); end
      end
      checks++; if (fill_busy !== 1'b0 || fill_done !== 1'b0) begin
         errors++; $display("FAIL %s post_fill busy/done got %b/%b exp 0/0", name, fill_busy, fill_done);
      end
   endtask

   task automatic test_fill_crit0();
      run_fill("crit0", 32'h0000_0100, 0, -1, 1'b0);
   endtask

   task automatic test_fill_wrap();
      run_fill("wrap", 32'h0000_011C, 0, -1, 1'b0);
   endtask

   task automatic test_fill_bubbles();
      run_fill("bubbles", $urandom, 1, -1, 1'b0);
   endtask

   task automatic test_store();
      store_valid = 1'b1; store_word = 3'd3; store_mask = 4'b0101; store_data = 32'hAABB_CCDD;
      #1;
      checks++; if (store_ready !== 1'b1) begin errors++; $display("FAIL store_ready got %b exp 1", store_ready); end
      @(posedge clk); @(negedge clk);
      store_valid = 1'b0;
      checks++; if (write !== 32'h0000_5000) begin errors++; $display("FAIL store write got %h exp 00005000", write); end
      checks++; if ((block[127:96] & 32'h00FF_00FF) !== 32'h00BB_00DD) begin
         errors++; $display("FAIL store word got %h exp xxBBxxDD", block[127:96]);
      end
      checks++; if ({block[255:128], block[95:0]} !== 224'h0) begin
         errors++; $display("FAIL store other_words got %h exp 0", {block[255:128], block[95:0]});
      end
      @(posedge clk); @(negedge clk);
      checks++; if (write !== 32'h0) begin errors++; $display("FAIL store_idle write got %h exp 0", write); end
   endtask

   task automatic test_store_random();
      bit          v;
      logic [2:0]  w;
      logic [3:0]  m;
      logic [31:0] dd;
      logic [31:0] care;
      for (int i = 0; i < 24; i++) begin
         v = 1'($urandom_range(0, 1)); w = 3'($urandom); m = 4'($urandom); dd = $urandom;
         store_valid = v; store_word = w; store_mask = m; store_data = dd;
         @(posedge clk); @(negedge clk);
         care = byte_bits(m);
         checks++; if (write !== (v ? exp_strobe(int'(w), m) : 32'h0)) begin
            errors++; $display("FAIL rstore%0d write got %h exp %h", i, write, v ? exp_strobe(int'(w), m) : 32'h0);
         end
         if (v) begin
            checks++; if ((block & ~exp_block(int'(w), ~care)) !== exp_block(int'(w), dd & care)) begin
               errors++; $display("FAIL rstore%0d block got %h exp %h", i, block, exp_block(int'(w), dd & care));
            end
         end
      end
      store_valid = 1'b0;
   endtask

   task automatic test_priority();
      logic [31:0] addr;
      addr = $urandom;
      store_valid = 1'b1; store_word = 3'd6; store_mask = 4'hF; store_data = 32'h1234_5678;
      fill_valid = 1'b1; fill_addr = addr;
      #1;
      checks++; if (fill_ready !== 1'b0 || store_ready !== 1'b1) begin
         errors++; $display("FAIL prio ready fill/store got %b/%b exp 0/1", fill_ready, store_ready);
      end
      @(posedge clk); @(negedge clk);
      store_valid = 1'b0;
      checks++; if (write !== 32'h0F00_0000 || block !== exp_block(6, 32'h1234_5678)) begin
         errors++; $display("FAIL prio store write got %h exp 0f000000", write);
      end
      checks++; if (fill_busy !== 1'b0 || mem_req_valid !== 1'b0) begin
         errors++; $display("FAIL prio fill_not_taken busy/req got %b/%b exp 0/0", fill_busy, mem_req_valid);
      end
      #1;
      checks++; if (fill_ready !== 1'b1) begin errors++; $display("FAIL prio fill_ready_next got %b exp 1", fill_ready); end
      run_fill("prio_fill", addr, 0, -1, 1'b0);
      run_fill("store_stall", $urandom, 2, -1, 1'b1);
   endtask

   task automatic test_ignored_rvalid();
      for (int i = 0; i < 4; i++) begin
         mem_rvalid = 1'b1; mem_rdata = $urandom;
         @(posedge clk); @(negedge clk);
         checks++; if (write !== 32'h0 || mem_rready !== 1'b0) begin
            errors++; $display("FAIL idle_rvalid write/rready got %h/%b exp 0/0", write, mem_rready);
         end
      end
      mem_rvalid = 1'b0;
   endtask

   task automatic test_reset_mid_fill();
      run_fill("midreset", $urandom, 0, 4, 1'b0);
      run_fill("after_reset", $urandom, 2, -1, 1'b0);
   endtask

   task automatic test_random_fills();
      for (int i = 0; i < 6; i++) run_fill("rand_fill", $urandom, 2, -1, 1'($urandom_range(0, 1)));
   endtask

   initial begin
      reset = 1'b1; fill_valid = 1'b0; fill_addr = '0; mem_req_ready = 1'b0;
      mem_rvalid = 1'b0; mem_rdata = '0; store_valid = 1'b0; store_word = '0;
      store_mask = '0; store_data = '0;
      @(negedge clk);
      test_reset();
      test_fill_crit0();
      test_fill_wrap();
      test_fill_bubbles();
      test_store();
      test_store_random();
      test_priority();
      test_ignored_rvalid();
      test_reset_mid_fill();
      test_random_fills();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
